// File: rtl/time_alarm_datapath.sv
// Purpose : Clock/alarm datapath. Keeps running time HH:MM:SS from a 1 Hz tick, holds alarm HH:MM
//           and an edit buffer stepped by auto-repeating hour/minute increment levels, drives the
//           display mux and a registered alarm-match flag.
// Latency : display outputs are combinational from state; loads/increments land on the next edge;
//           alarm_match_o is registered (one cycle after the compared state).
// Backpr. : none; all strobes are consumed in the cycle they are presented.
// Ports   : clk_i, rst_ni (async active-low), sec_tick_i, show_time_i, show_alarm_i, load_time_i,
//           load_alarm_i, increment_hour_i, increment_min_i, alarm_on_i ->
//           disp_hour_o[4:0], disp_min_o[5:0], disp_sec_o[5:0], alarm_match_o
module time_alarm_datapath #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sec_tick_i,
    input  logic       show_time_i,
    input  logic       show_alarm_i,
    input  logic       load_time_i,
    input  logic       load_alarm_i,
    input  logic       increment_hour_i,
    input  logic       increment_min_i,
    input  logic       alarm_on_i,
    output logic [4:0] disp_hour_o,
    output logic [5:0] disp_min_o,
    output logic [5:0] disp_sec_o,
    output logic       alarm_match_o
);

    // The repeat counter never exceeds max(HOLD_CYCLES, REPEAT_CYCLES) - 1.
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] SEC_MAX = 6'd59;

    // Running time
    logic [4:0] t_hr_q,  t_hr_d;
    logic [5:0] t_min_q, t_min_d;
    logic [5:0] t_sec_q, t_sec_d;

    // Alarm setting
    logic [4:0] a_hr_q,  a_hr_d;
    logic [5:0] a_min_q, a_min_d;

    // Edit buffer
    logic [4:0] e_hr_q,  e_hr_d;
    logic [5:0] e_min_q, e_min_d;

    logic alarm_match_q, alarm_match_d;

    // Auto-repeat generators; index 1 = hour field, index 0 = minute field.
    logic [1:0]         inc_lvl;
    logic [1:0]         inc_prev_q;
    logic [1:0][CW-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]         rep_ph_q,  rep_ph_d;   // 0: waiting for hold delay, 1: repeating
    logic [1:0]         inc_pulse;

    assign inc_lvl = {increment_hour_i, increment_min_i};

    // ------------------------------------------------------------------
    // Auto-repeat: pulse on the rising edge of the level, again after
    // HOLD_CYCLES-1 further cycles, then every REPEAT_CYCLES while held.
    // Releasing the level clears the counter and phase.
    // ------------------------------------------------------------------
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_ph_d  = rep_ph_q;
        inc_pulse = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (!inc_lvl[i]) begin
                rep_cnt_d[i] = '0;
                rep_ph_d[i]  = 1'b0;
            end else begin
                if (!inc_prev_q[i]) begin
                    inc_pulse[i] = 1'b1;
                end
                if (!rep_ph_q[i]) begin
                    if (rep_cnt_q[i] == HOLD_LAST) begin
                        inc_pulse[i] = 1'b1;
                        rep_cnt_d[i] = '0;
                        rep_ph_d[i]  = 1'b1;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + CW'(1);
                    end
                end else begin
                    if (rep_cnt_q[i] == REP_LAST) begin
                        inc_pulse[i] = 1'b1;
                        rep_cnt_d[i] = '0;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + CW'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Running time: a load replaces the time and swallows a same-cycle tick.
    // ------------------------------------------------------------------
    always_comb begin
        t_hr_d  = t_hr_q;
        t_min_d = t_min_q;
        t_sec_d = t_sec_q;
        if (load_time_i) begin
            t_hr_d  = e_hr_q;
            t_min_d = e_min_q;
            t_sec_d = '0;
        end else if (sec_tick_i) begin
            if (t_sec_q == SEC_MAX) begin
                t_sec_d = '0;
                if (t_min_q == MIN_MAX) begin
                    t_min_d = '0;
                    t_hr_d  = (t_hr_q == HR_MAX) ? 5'd0 : t_hr_q + 5'd1;
                end else begin
                    t_min_d = t_min_q + 6'd1;
                end
            end else begin
                t_sec_d = t_sec_q + 6'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Alarm setting: independent of load_time, both may happen together.
    // ------------------------------------------------------------------
    always_comb begin
        a_hr_d  = a_hr_q;
        a_min_d = a_min_q;
        if (load_alarm_i) begin
            a_hr_d  = e_hr_q;
            a_min_d = e_min_q;
        end
    end

    // ------------------------------------------------------------------
    // Edit buffer: show_time tracks the time, show_alarm copies the alarm,
    // otherwise increment pulses step each field without carry.
    // ------------------------------------------------------------------
    always_comb begin
        e_hr_d  = e_hr_q;
        e_min_d = e_min_q;
        if (show_time_i) begin
            e_hr_d  = t_hr_q;
            e_min_d = t_min_q;
        end else if (show_alarm_i) begin
            e_hr_d  = a_hr_q;
            e_min_d = a_min_q;
        end else begin
            if (inc_pulse[1]) begin
                e_hr_d = (e_hr_q == HR_MAX) ? 5'd0 : e_hr_q + 5'd1;
            end
            if (inc_pulse[0]) begin
                e_min_d = (e_min_q == MIN_MAX) ? 6'd0 : e_min_q + 6'd1;
            end
        end
    end

    // Compares the current registers, so the flag trails the time by one cycle.
    assign alarm_match_d = alarm_on_i && (t_hr_q == a_hr_q) && (t_min_q == a_min_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t_hr_q        <= '0;
            t_min_q       <= '0;
            t_sec_q       <= '0;
            a_hr_q        <= '0;
            a_min_q       <= '0;
            e_hr_q        <= '0;
            e_min_q       <= '0;
            alarm_match_q <= 1'b0;
            inc_prev_q    <= '0;
            rep_cnt_q     <= '0;
            rep_ph_q      <= '0;
        end else begin
            t_hr_q        <= t_hr_d;
            t_min_q       <= t_min_d;
            t_sec_q       <= t_sec_d;
            a_hr_q        <= a_hr_d;
            a_min_q       <= a_min_d;
            e_hr_q        <= e_hr_d;
            e_min_q       <= e_min_d;
            alarm_match_q <= alarm_match_d;
            inc_prev_q    <= inc_lvl;
            rep_cnt_q     <= rep_cnt_d;
            rep_ph_q      <= rep_ph_d;
        end
    end

    // ------------------------------------------------------------------
    // Display mux: alarm view has priority over time view; with neither
    // selected the edit buffer is shown so edits are visible live.
    // ------------------------------------------------------------------
    always_comb begin
        disp_hour_o = e_hr_q;
        disp_min_o  = e_min_q;
        if (show_alarm_i) begin
            disp_hour_o = a_hr_q;
            disp_min_o  = a_min_q;
        end else if (show_time_i) begin
            disp_hour_o = t_hr_q;
            disp_min_o  = t_min_q;
        end
    end

    assign disp_sec_o    = t_sec_q;
    assign alarm_match_o = alarm_match_q;

endmodule

// File: tb/tb_time_alarm_datapath.sv
module tb_time_alarm_datapath;

    localparam int HOLD = 4;
    localparam int REP  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0, show_time = 1'b0, show_alarm = 1'b0;
    logic       load_time = 1'b0, load_alarm = 1'b0;
    logic       increment_hour = 1'b0, increment_min = 1'b0, alarm_on = 1'b0;
    logic [4:0] disp_hour;
    logic [5:0] disp_min, disp_sec;
    logic       alarm_match;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    time_alarm_datapath #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .sec_tick_i       (sec_tick),
        .show_time_i      (show_time),
        .show_alarm_i     (show_alarm),
        .load_time_i      (load_time),
        .load_alarm_i     (load_alarm),
        .increment_hour_i (increment_hour),
        .increment_min_i  (increment_min),
        .alarm_on_i       (alarm_on),
        .disp_hour_o      (disp_hour),
        .disp_min_o       (disp_min),
        .disp_sec_o       (disp_sec),
        .alarm_match_o    (alarm_match)
    );

    // ---------------- reference model ----------------
    // Time as seconds-of-day, hold length as a count of held cycles.
    int m_t, m_ahr, m_amin, m_ehr, m_emin, m_khr, m_kmin, m_match;

    function automatic bit is_pulse(int p);
        return (p == 0) || (p == HOLD - 1) || (p > HOLD - 1 && ((p - (HOLD - 1)) % REP) == 0);
    endfunction

    task automatic model_reset();
        m_t = 0; m_ahr = 0; m_amin = 0; m_ehr = 0; m_emin = 0;
        m_khr = 0; m_kmin = 0; m_match = 0;
    endtask

    task automatic model_step();
        int nt, nah, nam, neh, nem, nm;
        bit ph, pm;
        ph  = increment_hour && is_pulse(m_khr);
        pm  = increment_min  && is_pulse(m_kmin);
        nt  = load_time ? (m_ehr * 3600 + m_emin * 60) : (sec_tick ? (m_t + 1) % 86400 : m_t);
        nah = load_alarm ? m_ehr  : m_ahr;
        nam = load_alarm ? m_emin : m_amin;
        neh = m_ehr; nem = m_emin;
        if (show_time) begin
            neh = m_t / 3600; nem = (m_t / 60) % 60;
        end else if (show_alarm) begin
            neh = m_ahr; nem = m_amin;
        end else begin
            if (ph) neh = (m_ehr + 1) % 24;
            if (pm) nem = (m_emin + 1) % 60;
        end
        nm = (alarm_on && (m_t / 60 == m_ahr * 60 + m_amin)) ? 1 : 0;
        m_khr  = increment_hour ? m_khr + 1 : 0;
        m_kmin = increment_min  ? m_kmin + 1 : 0;
        m_t = nt; m_ahr = nah; m_amin = nam; m_ehr = neh; m_emin = nem; m_match = nm;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        int eh, em;
        eh = show_alarm ? m_ahr  : (show_time ? m_t / 3600        : m_ehr);
        em = show_alarm ? m_amin : (show_time ? (m_t / 60) % 60   : m_emin);
        chk({tag, "_hr"},    int'(disp_hour),   eh);
        chk({tag, "_min"},   int'(disp_min),    em);
        chk({tag, "_sec"},   int'(disp_sec),    m_t % 60);
        chk({tag, "_match"}, int'(alarm_match), m_match);
    endtask

    typedef struct {
        logic tick, st, sa, lt, la, ih, im, on;
        int   hr, mn, sc, match;   // expected outputs; hr < 0 means no table check
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mkv(logic tick, logic st, logic sa, logic lt, logic la,
                                 logic ih, logic im, logic on,
                                 int hr = -1, int mn = 0, int sc = 0, int match = 0);
        vec_t v;
        v.tick = tick; v.st = st; v.sa = sa; v.lt = lt; v.la = la;
        v.ih = ih; v.im = im; v.on = on;
        v.hr = hr; v.mn = mn; v.sc = sc; v.match = match;
        return v;
    endfunction

    // One clock cycle: drive, sample at the falling edge, advance the model at the rising edge.
    task automatic step(input vec_t v, input string tag);
        sec_tick = v.tick; show_time = v.st; show_alarm = v.sa; load_time = v.lt;
        load_alarm = v.la; increment_hour = v.ih; increment_min = v.im; alarm_on = v.on;
        @(negedge clk);
        chk_model(tag);
        if (v.hr >= 0) begin
            chk({tag, "_tbl_hr"},    int'(disp_hour),   v.hr);
            chk({tag, "_tbl_min"},   int'(disp_min),    v.mn);
            chk({tag, "_tbl_sec"},   int'(disp_sec),    v.sc);
            chk({tag, "_tbl_match"}, int'(alarm_match), v.match);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) step(tbl[i], $sformatf("vec%0d", i));
    endtask

    // Walk the edit buffer to h:m with single taps (press one cycle, release one cycle).
    task automatic set_edit(input int h, input int m);
        int nh, nm;
        nh = (h - m_ehr + 24) % 24;
        nm = (m - m_emin + 60) % 60;
        for (int i = 0; i < nh; i++) begin
            step(mkv(0, 0, 0, 0, 0, 1, 0, 0), "tap_hr");
            step(mkv(0, 0, 0, 0, 0, 0, 0, 0), "tap_rel");
        end
        for (int i = 0; i < nm; i++) begin
            step(mkv(0, 0, 0, 0, 0, 0, 1, 0), "tap_min");
            step(mkv(0, 0, 0, 0, 0, 0, 0, 0), "tap_rel");
        end
    endtask

    task automatic do_reset(input string tag);
        sec_tick = 0; show_time = 0; show_alarm = 0; load_time = 0; load_alarm = 0;
        increment_hour = 0; increment_min = 0; alarm_on = 0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk({tag, "_hr"},    int'(disp_hour),   0);
        chk({tag, "_min"},   int'(disp_min),    0);
        chk({tag, "_sec"},   int'(disp_sec),    0);
        chk({tag, "_match"}, int'(alarm_match), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // T2: from 23:59:58 two ticks roll over to 00:00:00
        tbl[0]  = mkv(1, 1, 0, 0, 0, 0, 0, 0, 23, 59, 58, 0);
        tbl[1]  = mkv(1, 1, 0, 0, 0, 0, 0, 0, 23, 59, 59, 0);
        tbl[2]  = mkv(0, 1, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0);
        // T3: 10:20 shown, one hour tap, edit shows 11:20, then load
        tbl[3]  = mkv(0, 1, 0, 0, 0, 0, 0, 0, 10, 20, 0, 0);
        tbl[4]  = mkv(0, 0, 0, 0, 0, 1, 0, 0, 10, 20, 0, 0);
        tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 11, 20, 0, 0);
        tbl[6]  = mkv(0, 0, 0, 1, 0, 0, 0, 0, 11, 20, 0, 0);
        tbl[7]  = mkv(0, 1, 0, 0, 0, 0, 0, 0, 11, 20, 0, 0);
        // T5: load with a simultaneous tick, edit = 07:30
        tbl[8]  = mkv(1, 0, 0, 1, 0, 0, 0, 0,  7, 30, 0, 0);
        tbl[9]  = mkv(0, 1, 0, 0, 0, 0, 0, 0,  7, 30, 0, 0);
        // T4: minute held 10 cycles from 58, pulses at 0,3,5,7,9
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7, 58, 0, 0);
        tbl[11] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7, 59, 0, 0);
        tbl[12] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7, 59, 0, 0);
        tbl[13] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7, 59, 0, 0);
        tbl[14] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7,  0, 0, 0);
        tbl[15] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7,  0, 0, 0);
        tbl[16] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7,  1, 0, 0);
        tbl[17] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7,  1, 0, 0);
        tbl[18] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7,  2, 0, 0);
        tbl[19] = mkv(0, 0, 0, 0, 0, 0, 1, 0,  7,  2, 0, 0);
        tbl[20] = mkv(0, 0, 0, 0, 0, 0, 0, 0,  7,  3, 0, 0);
        // T6: alarm 06:45, time 06:44:59 ticks over; match one cycle later, gated by alarm_on
        tbl[21] = mkv(0, 1, 0, 0, 0, 0, 0, 1,  6, 44, 59, 0);
        tbl[22] = mkv(1, 1, 0, 0, 0, 0, 0, 1,  6, 44, 59, 0);
        tbl[23] = mkv(0, 1, 0, 0, 0, 0, 0, 1,  6, 45, 0, 0);
        tbl[24] = mkv(0, 1, 0, 0, 0, 0, 0, 1,  6, 45, 0, 1);
        tbl[25] = mkv(0, 1, 0, 0, 0, 0, 0, 0,  6, 45, 0, 1);
        tbl[26] = mkv(0, 1, 0, 0, 0, 0, 0, 0,  6, 45, 0, 0);
        tbl[27] = mkv(0, 0, 1, 0, 0, 0, 0, 0,  6, 45, 0, 0);
        tbl[28] = mkv(0, 0, 1, 0, 0, 0, 0, 1,  6, 45, 0, 0);
        tbl[29] = mkv(0, 1, 0, 0, 0, 0, 0, 1,  6, 45, 0, 1);

        // T1: reset
        do_reset("T1_reset");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "T1_idle");

        // T2
        set_edit(23, 59);
        step(mkv(0, 0, 0, 1, 0, 0, 0, 0), "T2_load");
        for (int i = 0; i < 58; i++) step(mkv(1, 0, 0, 0, 0, 0, 0, 0), "T2_tick");
        run_vec(0, 2);

        // T3
        set_edit(10, 20);
        step(mkv(0, 0, 0, 1, 0, 0, 0, 0), "T3_load");
        run_vec(3, 7);

        // T5
        set_edit(7, 30);
        run_vec(8, 9);

        // T4
        set_edit(7, 58);
        run_vec(10, 20);

        // T6
        set_edit(6, 45);
        step(mkv(0, 0, 0, 0, 1, 0, 0, 0), "T6_load_alarm");
        set_edit(6, 44);
        step(mkv(0, 0, 0, 1, 0, 0, 0, 0), "T6_load_time");
        for (int i = 0; i < 59; i++) step(mkv(1, 0, 0, 0, 0, 0, 0, 0), "T6_tick");
        run_vec(21, 29);

        // Randomized traffic against the model
        begin
            logic ih, im, on, st, sa;
            ih = 0; im = 0; on = 0; st = 0; sa = 0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(7) == 0)  ih = ~ih;
                if ($urandom_range(7) == 0)  im = ~im;
                if ($urandom_range(15) == 0) on = ~on;
                if ($urandom_range(9) == 0) begin
                    st = ($urandom_range(2) == 0);
                    sa = ($urandom_range(3) == 0);
                end
                step(mkv(($urandom_range(2) == 0), st, sa,
                         ($urandom_range(19) == 0), ($urandom_range(19) == 0),
                         ih, im, on), "rand");
            end
        end

        // Reset in the middle of a held minute increment aborts the edit
        for (int i = 0; i < 6; i++) step(mkv(0, 0, 0, 0, 0, 0, 1, 0), "hold_pre_rst");
        do_reset("mid_rst");
        step(mkv(0, 0, 0, 0, 0, 0, 1, 0), "post_rst_a");
        step(mkv(0, 0, 0, 0, 0, 0, 1, 0), "post_rst_b");
        chk("post_rst_edit_min", int'(disp_min), 1);
        chk("post_rst_edit_hr",  int'(disp_hour), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
